bus_gen_arbiter: RTL and testbench
==================================

# bus_gen_arbiter

Shared-bus generator and round-robin arbiter connecting `drvrs` device FIFOs on each of `bits` independent buses. On each bus it selects one pending source, pops its head packet, and pushes that packet into the destination device FIFO named in the packet header, or into all other devices for broadcast. It sits between the per-device driver/receiver FIFOs (via `bus_if`) and is the only shared resource in the bus subsystem.

## Interface
- `bits`, 1: number of independent buses.
- `drvrs`, 4: devices per bus (2..255).
- `pckg_sz`, 16: packet width in bits (≥ 9).
- `broadcast`, 8'hFF: destination ID meaning "all devices except the source".
- `clk` input, 1: single clock; all logic on the rising edge.
- `reset` input, 1: asynchronous, active-high.
- `pndng` input, [bits][drvrs] x 1: source FIFO of device d on bus b is non-empty.
- `D_pop` input, [bits][drvrs] x pckg_sz: head-of-FIFO data of each source; valid while `pndng` is high.
- `pop` output, [bits][drvrs] x 1: one-cycle pop strobe to the granted source FIFO.
- `push` output, [bits][drvrs] x 1: one-cycle write strobe into destination device FIFOs.
- `D_push` output, [bits][drvrs] x pckg_sz: packet driven to devices. The same value goes to every device on a bus.

## Operation
- Each bus has its own arbiter, FSM and packet register. Buses are fully independent.
- Packet header: destination ID = `packet[pckg_sz-1 -: 8]`. The remaining bits are payload and are not interpreted.
- Arbitration is round-robin. The search starts at `last_grant+1` (mod `drvrs`) and grants the first device with `pndng`=1. `last_grant` resets to `drvrs-1`, so device 0 wins first.
- FSM states per bus:
  - IDLE: if any `pndng`, register the grant and go to POP; otherwise stay.
  - POP: assert `pop[granted]`, capture `D_pop[granted]` into the packet register, update `last_grant`, then go to PUSH.
  - PUSH: drive `D_push` with the packet and assert `push` as follows, then go to IDLE.
    - Destination < `drvrs`: `push[dest]` only. A destination equal to the source is delivered normally.
    - Destination == `broadcast`: `push[d]` for every d ≠ source.
    - Any other destination: no push. The packet is dropped silently.
- No more than one `pop` and one delivery is active per bus at any time.
- The arbiter does not check destination FIFO fullness. The receiver side must accept every push.

## Timing
- Reset (async assert): all `pop`/`push` = 0, all `D_push` = 0, FSM = IDLE, packet register = 0, `last_grant` = `drvrs-1`. Outputs return to these values immediately on assertion, even mid-transaction. A packet already popped but not yet pushed is lost.
- Latency: `pndng` seen high at edge N → `pop` high during cycle N+1 → `push` high during cycle N+2 → IDLE in cycle N+3.
- Throughput: one packet per 3 cycles per bus.
- `D_pop` is sampled at the edge that ends the POP cycle, i.e. the same edge on which the FIFO pops.
- `D_push` holds the last packet after PUSH until the next PUSH, which lets checkers sample it late.
- `pndng` changes outside IDLE are ignored. A source that drops `pndng` during POP still gets popped. The source must not deassert `pndng` before the pop.
- Simultaneous requests are resolved purely by round-robin order. No requester waits more than `drvrs` grants.

## Test plan
- Reset, then device 0 pending with `D_pop[0][0]`=16'h0102: `pop[0][0]` pulses one cycle, next cycle `push[0][1]`=1 only with `D_push`=16'h0102; all other strobes stay 0.
- Devices 0–3 all pending with dest IDs 1,2,3,0: grants go in order 0,1,2,3, 3 cycles apart, and each packet reaches its destination.
- Device 2 sends 16'hFFAB: one cycle of `push` on devices 0, 1 and 3, no push on device 2, `D_push`=16'hFFAB.
- Device 1 sends 16'h07CD (dest 7 with `drvrs`=4): `pop[0][1]` pulses and no `push` follows; the FSM returns to IDLE.
- Continuous `pndng` on devices 0 and 3: grants alternate 0,3,0,3 and neither device starves.
- Assert `reset` during the PUSH cycle: `push`/`D_push` clear asynchronously. After release, the next grant goes to device 0.

Source files
------------

// File: rtl/bus_gen_arbiter.sv
// Shared-bus generator: per bus, a round-robin arbiter pops one pending source
// FIFO and delivers its packet to the addressed device (or to all others on broadcast).
module bus_gen_arbiter #(
    parameter int          bits      = 1,
    parameter int          drvrs     = 4,
    parameter int          pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [bits-1:0][drvrs-1:0]               pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_pop,
    output logic [bits-1:0][drvrs-1:0]               pop,
    output logic [bits-1:0][drvrs-1:0]               push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_push
);

    localparam int GW = (drvrs > 1) ? $clog2(drvrs) : 1;
    localparam logic [drvrs-1:0] ONE = {{(drvrs-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_e;

    // First requester after 'last' in circular order; 'last' itself is checked last.
    function automatic logic [GW-1:0] rr_pick(input logic [drvrs-1:0] req,
                                              input logic [GW-1:0]    last);
        logic [GW-1:0] pick;
        logic          found;
        logic          hit;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= drvrs; i++) begin
            idx   = (int'(last) + i) % drvrs;
            hit   = !found && req[GW'(idx)];
            pick  = hit ? GW'(idx) : pick;
            found = found | hit;
        end
        return pick;
    endfunction

    // Out-of-range destinations yield an empty mask, which drops the packet.
    function automatic logic [drvrs-1:0] dest_mask(input logic [7:0]    dest,
                                                   input logic [GW-1:0] src);
        logic [drvrs-1:0] mask;
        if (dest == broadcast) begin
            mask = ~(ONE << src);
        end else if (int'(dest) < drvrs) begin
            mask = ONE << dest;
        end else begin
            mask = '0;
        end
        return mask;
    endfunction

    for (genvar b = 0; b < bits; b++) begin : g_bus
        state_e             state_q, state_d;
        logic [GW-1:0]      grant_q, grant_d;
        logic [GW-1:0]      last_q, last_d;
        logic [drvrs-1:0]   pop_q, pop_d;
        logic [drvrs-1:0]   push_q, push_d;
        logic [pckg_sz-1:0] pkt_q, pkt_d;

        // Next-state and next-output computation for this bus.
        always_comb begin
            state_d = state_q;
            grant_d = grant_q;
            last_d  = last_q;
            pkt_d   = pkt_q;
            pop_d   = '0;
            push_d  = '0;
            case (state_q)
                IDLE: begin
                    if (|pndng[b]) begin
                        grant_d = rr_pick(pndng[b], last_q);
                        pop_d   = ONE << grant_d;
                        state_d = POP;
                    end else begin
                        state_d = IDLE;
                    end
                end
                POP: begin
                    pkt_d   = D_pop[b][grant_q];
                    last_d  = grant_q;
                    push_d  = dest_mask(D_pop[b][grant_q][pckg_sz-1 -: 8], grant_q);
                    state_d = PUSH;
                end
                PUSH: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // State, packet and strobe registers; async reset returns the bus to idle.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= IDLE;
                grant_q <= '0;
                last_q  <= GW'(drvrs - 1);
                pkt_q   <= '0;
                pop_q   <= '0;
                push_q  <= '0;
            end else begin
                state_q <= state_d;
                grant_q <= grant_d;
                last_q  <= last_d;
                pkt_q   <= pkt_d;
                pop_q   <= pop_d;
                push_q  <= push_d;
            end
        end

        assign pop[b]    = pop_q;
        assign push[b]   = push_q;
        assign D_push[b] = {drvrs{pkt_q}};
    end

endmodule

// File: tb/tb_bus_gen_arbiter.sv
// Scoreboard bench for bus_gen_arbiter: device FIFO models feed the DUT, a
// transaction-level model predicts pop/push events, a monitor compares them.
module tb_bus_gen_arbiter;

    localparam int NDRV = 4;
    localparam int PW   = 16;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic rst_next = 1'b1;
    logic [0:0][NDRV-1:0]         pndng;
    logic [0:0][NDRV-1:0][PW-1:0] D_pop;
    logic [0:0][NDRV-1:0]         pop;
    logic [0:0][NDRV-1:0]         push;
    logic [0:0][NDRV-1:0][PW-1:0] D_push;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int              cyc;
        logic [NDRV-1:0] mask;
        logic [PW-1:0]   data;
    } ev_t;

    ev_t             exp_pop[$];
    ev_t             exp_push[$];
    logic [PW-1:0]   devq[NDRV][$];
    int              last_g        = NDRV - 1;
    int              free_at       = 0;
    int              push_cyc_last = -1;
    logic [NDRV-1:0] deq_prev      = '0;

    bus_gen_arbiter #(.bits(1), .drvrs(NDRV), .pckg_sz(PW), .broadcast(8'hFF)) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (D_pop),
        .pop    (pop),
        .push   (push),
        .D_push (D_push)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    // Transaction model: when the bus is free, the next pending device after the
    // last grant is served; pop one cycle later, delivery the cycle after that.
    task automatic predict();
        logic [NDRV-1:0] pend;
        logic [NDRV-1:0] m;
        logic [PW-1:0]   pkt;
        logic [7:0]      dest;
        int              g;
        bit              found;
        for (int d = 0; d < NDRV; d++) pend[d] = (devq[d].size() > 0);
        if (!reset && cyc >= free_at && pend != '0) begin
            found = 1'b0;
            g = 0;
            for (int i = 1; i <= NDRV; i++) begin
                if (!found && pend[(last_g + i) % NDRV]) begin
                    g = (last_g + i) % NDRV;
                    found = 1'b1;
                end
            end
            pkt  = devq[g][0];
            dest = pkt[15:8];
            if (dest == 8'hFF)      m = ~(4'b0001 << g);
            else if (dest < 8'd4)   m = 4'b0001 << dest;
            else                    m = 4'b0000;
            exp_pop.push_back('{cyc + 1, 4'b0001 << g, pkt});
            exp_push.push_back('{cyc + 2, m, pkt});
            last_g        = g;
            free_at       = cyc + 3;
            push_cyc_last = cyc + 2;
        end
    endtask

    task automatic clear_model();
        exp_pop.delete();
        exp_push.delete();
        last_g   = NDRV - 1;
        free_at  = 0;
        deq_prev = '0;
    endtask

    // One cycle of stimulus, driven just after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
        reset = rst_next;
        if (reset) clear_model();
        for (int d = 0; d < NDRV; d++)
            if (deq_prev[d] && devq[d].size() > 0) void'(devq[d].pop_front());
        deq_prev = pop[0];
        for (int d = 0; d < NDRV; d++) begin
            pndng[0][d] = (devq[d].size() > 0);
            D_pop[0][d] = (devq[d].size() > 0) ? devq[d][0] : 16'($urandom);
        end
        predict();
    endtask

    task automatic do_reset();
        rst_next = 1'b1;
        step();
        step();
        rst_next = 1'b0;
    endtask

    function automatic bit all_idle();
        bit idle;
        idle = (exp_pop.size() == 0) && (exp_push.size() == 0);
        for (int d = 0; d < NDRV; d++) idle = idle && (devq[d].size() == 0);
        return idle;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while (!all_idle() && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (!all_idle()) begin
            failures++;
            $display("FAIL drain timeout cyc=%0d pending_pops=%0d pending_pushes=%0d",
                     cyc, exp_pop.size(), exp_push.size());
        end
    endtask

    // Monitor: every falling edge, compare strobes (and data on delivery) with the scoreboard.
    initial begin
        ev_t             e;
        logic [NDRV-1:0] ep;
        forever begin
            @(negedge clk);
            ep = '0;
            if (exp_pop.size() > 0 && exp_pop[0].cyc == cyc) begin
                e  = exp_pop.pop_front();
                ep = e.mask;
            end
            chk("pop", 64'(pop[0]), 64'(ep));
            if (exp_push.size() > 0 && exp_push[0].cyc == cyc) begin
                e = exp_push.pop_front();
                chk("push", 64'(push[0]), 64'(e.mask));
                chk("D_push", 64'(D_push[0]), 64'({NDRV{e.data}}));
            end else begin
                chk("push_idle", 64'(push[0]), 64'd0);
            end
        end
    end

    initial begin
        pndng = '0;
        D_pop = '0;
        step();
        step();
        chk("reset_dpush", 64'(D_push[0]), 64'd0);

        // Single unicast from device 0 to device 1.
        devq[0].push_back(16'h0102);
        rst_next = 1'b0;
        drain();

        // All four pending right after reset: order 0,1,2,3.
        do_reset();
        devq[0].push_back(16'h0110);
        devq[1].push_back(16'h0211);
        devq[2].push_back(16'h0312);
        devq[3].push_back(16'h0013);
        drain();

        // Broadcast from device 2, then a dropped packet from device 1.
        devq[2].push_back(16'hFFAB);
        drain();
        devq[1].push_back(16'h07CD);
        drain();
        chk("drop_dpush_hold", 64'(D_push[0]), 64'({NDRV{16'h07CD}}));

        // Two continuously pending sources alternate.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            devq[0].push_back(16'h0100 | 16'(i));
            devq[3].push_back(16'h0230 | 16'(i));
        end
        drain();

        // Async reset during delivery, then the next grant restarts at device 0.
        do_reset();
        push_cyc_last = -1;
        devq[1].push_back(16'h03AA);
        for (int i = 0; i < 10 && cyc != push_cyc_last; i++) step();
        chk("push_before_reset", 64'(push[0]), 64'(4'b1000));
        reset    = 1'b1;
        rst_next = 1'b1;
        #1;
        chk("async_pop", 64'(pop[0]), 64'd0);
        chk("async_push", 64'(push[0]), 64'd0);
        chk("async_dpush", 64'(D_push[0]), 64'd0);
        clear_model();
        step();
        step();
        devq[0].push_back(16'h01B0);
        devq[2].push_back(16'h01C0);
        rst_next = 1'b0;
        drain();

        // Randomised traffic mixing unicast, broadcast and dropped destinations.
        for (int t = 0; t < 400; t++) begin
            for (int d = 0; d < NDRV; d++) begin
                if ($urandom_range(0, 3) == 0 && devq[d].size() < 4) begin
                    logic [7:0] dst;
                    int         r;
                    r = int'($urandom_range(0, 5));
                    if (r < 4)       dst = 8'(r);
                    else if (r == 4) dst = 8'hFF;
                    else             dst = 8'($urandom);
                    devq[d].push_back({dst, 8'($urandom)});
                end
            end
            step();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
